fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Fetch stage of the five-stage pipeline: owns the PC, issues instruction-memory requests and loads the IF/ID register.
- Consumes the hazard controls: `stall` freezes the PC and IF/ID; `flush` redirects the PC and squashes fetched work.
- Sits between instruction memory and the decode stage. At most one memory request is outstanding; a one-entry hold buffer absorbs a response that arrives during a stall.

Parameters:
- REG_WIDTH, 64, PC/address width.
- INSTR_WIDTH, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- stall  input  1  freeze the PC and IF/ID; from the hazard unit.
- flush  input  1  squash and redirect; from the hazard unit.
- redirect_pc  input  REG_WIDTH  branch/jal/jalr target, sampled when flush=1.
- imem_req  output  1  request strobe; one cycle per request.
- imem_addr  output  REG_WIDTH  request address, valid when imem_req=1.
- imem_rvalid  input  1  response strobe; arrives 1 or more cycles after its req.
- imem_rdata  input  INSTR_WIDTH  response instruction.
- if_id_valid  output  1  IF/ID holds a real instruction.
- if_id_pc  output  REG_WIDTH  PC of the IF/ID instruction.
- if_id_instr  output  INSTR_WIDTH  IF/ID instruction; NOP when invalid.

Behaviour:
- Reset (clk edge with rst=1):
  - pc<=RESET_PC; state<=FETCH; buffer cleared.
  - if_id_valid<=0, if_id_pc<=0, if_id_instr<=NOP (32'h00000013).
  - imem_req is forced to 0 while rst=1.
  - A response arriving after reset, for a request made before reset, is ignored. The bench does not create this case.
- States: FETCH, WAIT, DROP.
- imem_req = (state==FETCH) && !buf_valid && !flush && !rst; imem_addr = pc.
- FETCH:
  - If imem_req=1: req_pc<=pc, pc<=pc+4 (width wrap modulo 2^REG_WIDTH), go to WAIT.
  - Otherwise stay in FETCH.
- WAIT: on imem_rvalid, deliver (req_pc, imem_rdata), then go to FETCH.
- Delivery:
  - stall=0: IF/ID loads {1, req_pc, rdata}.
  - stall=1: the hold buffer captures it (buf_valid<=1).
- IF/ID update when flush=0:
  - stall=1: hold all IF/ID fields.
  - stall=0 and buf_valid: load from the buffer; buf_valid<=0.
  - stall=0 and a delivery this cycle: load the delivery.
  - stall=0 otherwise: if_id_valid<=0, if_id_instr<=NOP, if_id_pc holds.
  - The buffer and a new delivery can never coexist, because no request is issued while buf_valid.
- Flush (priority over stall and over everything else except rst):
  - pc<=redirect_pc; buf_valid<=0; if_id_valid<=0; if_id_instr<=NOP.
  - State WAIT with rvalid this cycle: discard the response, go to FETCH.
  - State WAIT without rvalid: go to DROP.
  - State FETCH: no request this cycle; stay in FETCH.
  - State DROP: stay in DROP.
- DROP: imem_req=0; on imem_rvalid discard the data and go to FETCH.
- imem_rvalid in FETCH (no request outstanding) is a protocol error. It is ignored, with an assertion in simulation.
- Latency: req at cycle t, rvalid at t+k; with stall=0, if_id_valid is high at t+k+1.
- Throughput: with 1-cycle memory, one instruction per 2 cycles.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined:
  - Adds outputs perf_fetched[31:0] (IF/ID loads with valid=1) and perf_dropped[31:0] (responses discarded by flush/DROP).
  - Both counters are cleared by rst and saturate at 32'hFFFFFFFF.
- When undefined: these ports and the counter logic do not exist; all other behaviour is identical.

Decomposition:
- Package pipeline_pkg holds:
  - XLEN / INSTR_WIDTH defaults.
  - NOP_INSTR = 32'h00000013.
  - fetch_state_e enum {FETCH, WAIT, DROP}.
- Sub-module fetch_hold_buf: one-entry buffer holding {pc, instr}. Ports: capture, release, clear, buf_valid.

Test Plan:
- Reset with RESET_PC=0x100, then release rst, 1-cycle memory returning 0xAAAA0001 → first imem_req with addr 0x100; IF/ID valid, pc 0x100, instr 0xAAAA0001 two cycles after the request.
- stall=1 for 3 cycles while the response for 0x104 arrives → response captured in the buffer, no new imem_req, IF/ID holds 0x100; after stall drops, IF/ID = 0x104 on the next edge.
- flush with redirect_pc=0x200 in WAIT, response delayed 3 cycles → DROP entered, that response discarded, next imem_addr=0x200, IF/ID shows no valid entry in between.
- flush and stall together in the same cycle in which rvalid arrives → response discarded, IF/ID invalid with instr 0x13, pc=redirect_pc, state FETCH.
- PC at 0xFFFF_FFFF_FFFF_FFFC fetched → next imem_addr wraps to 0x0.
- FETCH_PERF_EN defined, 5 delivered instructions and 2 flushed in-flight responses → perf_fetched=5, perf_dropped=2; both cleared by rst.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the fetch stage.
// Optional perf counters elsewhere are enabled by defining FETCH_PERF_EN.
package pipeline_pkg;
   localparam int unsigned XLEN    = 64;
   localparam int unsigned INSTR_W = 32;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   typedef enum logic [1:0] {
      FETCH,
      WAIT,
      DROP
   } fetch_state_e;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: hazard controls, instruction-memory handshake and IF/ID outputs.
// master = fetch unit side, slave = environment (hazard unit, imem, decode).
interface fetch_unit_if #(
   parameter int unsigned REG_WIDTH   = pipeline_pkg::XLEN,
   parameter int unsigned INSTR_WIDTH = pipeline_pkg::INSTR_W
);
   logic                   stall;
   logic                   flush;
   logic [REG_WIDTH-1:0]   redirect_pc;
   logic                   imem_req;
   logic [REG_WIDTH-1:0]   imem_addr;
   logic                   imem_rvalid;
   logic [INSTR_WIDTH-1:0] imem_rdata;
   logic                   if_id_valid;
   logic [REG_WIDTH-1:0]   if_id_pc;
   logic [INSTR_WIDTH-1:0] if_id_instr;

   modport master (
      input  stall, flush, redirect_pc, imem_rvalid, imem_rdata,
      output imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr
   );

   modport slave (
      output stall, flush, redirect_pc, imem_rvalid, imem_rdata,
      input  imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr
   );
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry {pc, instr} buffer absorbing a fetch response that lands during a stall.
module fetch_hold_buf #(
   parameter int unsigned REG_WIDTH   = 64,
   parameter int unsigned INSTR_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   capture_i,
   input  logic                   release_i,
   input  logic                   clear_i,
   input  logic [REG_WIDTH-1:0]   pc_i,
   input  logic [INSTR_WIDTH-1:0] instr_i,
   output logic                   buf_valid_o,
   output logic [REG_WIDTH-1:0]   buf_pc_o,
   output logic [INSTR_WIDTH-1:0] buf_instr_o
);
   logic                   valid_q, valid_d;
   logic [REG_WIDTH-1:0]   pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;

   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (capture_i) begin
         valid_d = 1'b1;
         pc_d    = pc_i;
         instr_d = instr_i;
      end else if (release_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         instr_q <= '0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign buf_valid_o = valid_q;
   assign buf_pc_o    = pc_q;
   assign buf_instr_o = instr_q;
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues one outstanding imem request, loads IF/ID.
// Define FETCH_PERF_EN to add perf_fetched / perf_dropped saturating counters.
module fetch_unit
   import pipeline_pkg::*;
#(
   parameter int unsigned          REG_WIDTH   = 64,
   parameter int unsigned          INSTR_WIDTH = 32,
   parameter logic [REG_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                clk,
   input  logic                rst,
   fetch_unit_if.master        bus
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]         perf_fetched,
   output logic [31:0]         perf_dropped
`endif
);
   localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(NOP_INSTR);

   fetch_state_e           state_q, state_d;
   logic [REG_WIDTH-1:0]   pc_q, pc_d;
   logic [REG_WIDTH-1:0]   req_pc_q, req_pc_d;
   logic                   ifv_q, ifv_d;
   logic [REG_WIDTH-1:0]   ifpc_q, ifpc_d;
   logic [INSTR_WIDTH-1:0] ifin_q, ifin_d;

   logic                   req;
   logic                   deliver;
   logic                   discard;
   logic                   buf_valid;
   logic [REG_WIDTH-1:0]   buf_pc;
   logic [INSTR_WIDTH-1:0] buf_instr;
   logic                   buf_release;
   logic                   load_valid;

   assign req         = (state_q == FETCH) && !buf_valid && !bus.flush && !rst;
   assign deliver     = (state_q == WAIT) && bus.imem_rvalid && !bus.flush;
   assign discard     = bus.imem_rvalid &&
                        ((state_q == DROP) || ((state_q == WAIT) && bus.flush));
   assign buf_release = !bus.flush && !bus.stall && buf_valid;
   assign load_valid  = !bus.flush && !bus.stall && (buf_valid || deliver);

   assign bus.imem_req    = req;
   assign bus.imem_addr   = pc_q;
   assign bus.if_id_valid = ifv_q;
   assign bus.if_id_pc    = ifpc_q;
   assign bus.if_id_instr = ifin_q;

   fetch_hold_buf #(
      .REG_WIDTH   (REG_WIDTH),
      .INSTR_WIDTH (INSTR_WIDTH)
   ) u_hold_buf (
      .clk         (clk),
      .rst         (rst),
      .capture_i   (deliver && bus.stall),
      .release_i   (buf_release),
      .clear_i     (bus.flush),
      .pc_i        (req_pc_q),
      .instr_i     (bus.imem_rdata),
      .buf_valid_o (buf_valid),
      .buf_pc_o    (buf_pc),
      .buf_instr_o (buf_instr)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      unique case (state_q)
         FETCH: begin
            if (req) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + REG_WIDTH'(4);
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (bus.imem_rvalid) state_d = FETCH;
            else if (bus.flush)  state_d = DROP;
         end
         DROP: begin
            // A response here always retires the squashed request, flush or not.
            if (bus.imem_rvalid) state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
      if (bus.flush) pc_d = bus.redirect_pc;
   end

   always_comb begin
      ifv_d  = ifv_q;
      ifpc_d = ifpc_q;
      ifin_d = ifin_q;
      if (bus.flush) begin
         ifv_d  = 1'b0;
         ifin_d = NOP;
      end else if (!bus.stall) begin
         if (buf_valid) begin
            ifv_d  = 1'b1;
            ifpc_d = buf_pc;
            ifin_d = buf_instr;
         end else if (deliver) begin
            ifv_d  = 1'b1;
            ifpc_d = req_pc_q;
            ifin_d = bus.imem_rdata;
         end else begin
            ifv_d  = 1'b0;
            ifin_d = NOP;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         req_pc_q <= '0;
         ifv_q    <= 1'b0;
         ifpc_q   <= '0;
         ifin_q   <= NOP;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         ifv_q    <= ifv_d;
         ifpc_q   <= ifpc_d;
         ifin_q   <= ifin_d;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] fetched_q, fetched_d;
   logic [31:0] dropped_q, dropped_d;

   always_comb begin
      fetched_d = fetched_q;
      dropped_d = dropped_q;
      if (load_valid && (fetched_q != '1)) fetched_d = fetched_q + 32'd1;
      if (discard && (dropped_q != '1))    dropped_d = dropped_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetched_q <= '0;
         dropped_q <= '0;
      end else begin
         fetched_q <= fetched_d;
         dropped_q <= dropped_d;
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_dropped = dropped_q;
`else
   logic unused_perf;
   assign unused_perf = load_valid ^ discard;
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(bus.imem_rvalid && (state_q == FETCH)))
            else $error("imem_rvalid with no request outstanding");
      end
   end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random stall/flush/latency.
// Build with FETCH_PERF_EN defined to also check the perf counters.
module tb_fetch_unit;
   localparam logic [63:0] RST_PC = 64'h100;
   localparam logic [31:0] NOPV   = 32'h00000013;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_unit_if #(.REG_WIDTH(64), .INSTR_WIDTH(32)) bus ();

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_dropped;
`endif

   fetch_unit #(
      .REG_WIDTH   (64),
      .INSTR_WIDTH (32),
      .RESET_PC    (RST_PC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_dropped (perf_dropped)
`endif
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: PC counter, one outstanding request, held responses, IF/ID.
   logic        m_known = 1'b0;
   logic [63:0] m_pc, m_rpc, m_ipc;
   logic        m_out, m_sq, m_v;
   logic [31:0] m_instr;
   logic [31:0] m_fetched, m_dropped;
   ent_t        hq[$];

   // Memory model
   logic        mem_pend = 1'b0;
   int          mem_cnt  = 0;
   int          mem_k    = 1;
   logic [31:0] mem_next = 32'hAAAA0001;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic exp_req();
      return !rst && !m_out && (hq.size() == 0) && !bus.flush;
   endfunction

   function automatic logic [31:0] sat(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always @(posedge clk) begin
      logic er, resp, dlv;
      ent_t e;
      if (rst) begin
         m_known = 1'b1;
         m_pc = RST_PC; m_rpc = '0; m_out = 1'b0; m_sq = 1'b0;
         hq.delete();
         m_v = 1'b0; m_ipc = '0; m_instr = NOPV;
         m_fetched = '0; m_dropped = '0;
      end else begin
         er   = exp_req();
         resp = bus.imem_rvalid && m_out;
         dlv  = resp && !m_sq && !bus.flush;
         if (resp) begin
            m_out = 1'b0;
            if (!dlv) m_dropped = sat(m_dropped);
         end
         if (bus.flush && m_out) m_sq = 1'b1;
         if (er) begin
            m_out = 1'b1; m_sq = 1'b0; m_rpc = m_pc; m_pc = m_pc + 64'd4;
         end
         if (bus.flush) m_pc = bus.redirect_pc;
         if (bus.flush) begin
            hq.delete();
            m_v = 1'b0; m_instr = NOPV;
         end else if (bus.stall) begin
            if (dlv) hq.push_back('{pc: m_rpc, instr: bus.imem_rdata});
         end else if (hq.size() != 0) begin
            e = hq.pop_front();
            m_v = 1'b1; m_ipc = e.pc; m_instr = e.instr;
            m_fetched = sat(m_fetched);
         end else if (dlv) begin
            m_v = 1'b1; m_ipc = m_rpc; m_instr = bus.imem_rdata;
            m_fetched = sat(m_fetched);
         end else begin
            m_v = 1'b0; m_instr = NOPV;
         end
      end
   end

   // Per-cycle compare of every DUT output against the model
   always @(negedge clk) begin
      #1;
      chk("imem_req", {63'd0, bus.imem_req}, {63'd0, exp_req()});
      if (bus.imem_req && exp_req()) chk("imem_addr", bus.imem_addr, m_pc);
      if (m_known) begin
         chk("if_id_valid", {63'd0, bus.if_id_valid}, {63'd0, m_v});
         chk("if_id_pc", bus.if_id_pc, m_ipc);
         chk("if_id_instr", {32'd0, bus.if_id_instr}, {32'd0, m_instr});
`ifdef FETCH_PERF_EN
         chk("perf_fetched", {32'd0, perf_fetched}, {32'd0, m_fetched});
         chk("perf_dropped", {32'd0, perf_dropped}, {32'd0, m_dropped});
`endif
      end
   end

   // One cycle: drive inputs after negedge, memory responds, capture requests.
   task automatic step(input logic r, input logic s, input logic f, input logic [63:0] rd);
      @(negedge clk);
      rst = r;
      bus.stall = s;
      bus.flush = f;
      bus.redirect_pc = rd;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = $urandom;
      if (r) begin
         mem_pend = 1'b0;
      end else if (mem_pend) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            mem_pend = 1'b0;
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata = mem_next;
            mem_next = $urandom;
         end
      end
      #1;
      if (bus.imem_req) begin
         mem_pend = 1'b1;
         mem_cnt = mem_k;
      end
      #2;
   endtask

   initial begin
      logic [63:0] rd;
      bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect_pc = '0;
      bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;

      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("rst_req", {63'd0, bus.imem_req}, 64'd0);
      chk("rst_valid", {63'd0, bus.if_id_valid}, 64'd0);
      chk("rst_instr", {32'd0, bus.if_id_instr}, 64'h13);
      chk("rst_pc", bus.if_id_pc, 64'd0);
`ifdef FETCH_PERF_EN
      chk("rst_perf_f", {32'd0, perf_fetched}, 64'd0);
      chk("rst_perf_d", {32'd0, perf_dropped}, 64'd0);
`endif
      mem_k = 1;
      step(0, 0, 0, 0);
      chk("first_req", {63'd0, bus.imem_req}, 64'd1);
      chk("first_addr", bus.imem_addr, 64'h100);
      step(0, 0, 0, 0);
      chk("lat_not_yet", {63'd0, bus.if_id_valid}, 64'd0);
      step(0, 1, 0, 0);
      chk("lat_valid", {63'd0, bus.if_id_valid}, 64'd1);
      chk("lat_pc", bus.if_id_pc, 64'h100);
      chk("lat_instr", {32'd0, bus.if_id_instr}, 64'hAAAA0001);
      chk("second_addr", bus.imem_addr, 64'h104);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      chk("stall_no_req", {63'd0, bus.imem_req}, 64'd0);
      chk("stall_hold_pc", bus.if_id_pc, 64'h100);
      step(0, 0, 0, 0);
      chk("unstall_hold_pc", bus.if_id_pc, 64'h100);
      mem_k = 3;
      step(0, 0, 0, 0);
      chk("buf_release_pc", bus.if_id_pc, 64'h104);
      chk("buf_release_v", {63'd0, bus.if_id_valid}, 64'd1);
      step(0, 0, 1, 64'h200);
      step(0, 0, 0, 0);
      chk("drop_no_req", {63'd0, bus.imem_req}, 64'd0);
      step(0, 0, 0, 0);
      chk("drop_invalid", {63'd0, bus.if_id_valid}, 64'd0);
      mem_k = 1;
      step(0, 0, 0, 0);
      chk("redirect_addr", bus.imem_addr, 64'h200);
      chk("redirect_invalid", {63'd0, bus.if_id_valid}, 64'd0);
      step(0, 1, 1, 64'h300);
      step(0, 0, 0, 0);
      chk("fs_invalid", {63'd0, bus.if_id_valid}, 64'd0);
      chk("fs_instr", {32'd0, bus.if_id_instr}, 64'h13);
      chk("fs_req", {63'd0, bus.imem_req}, 64'd1);
      chk("fs_addr", bus.imem_addr, 64'h300);
      step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
      step(0, 0, 0, 0);
      chk("wrap_top", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
`ifdef FETCH_PERF_EN
      chk("perf_f_dir", {32'd0, perf_fetched}, 64'd2);
      chk("perf_d_dir", {32'd0, perf_dropped}, 64'd3);
`endif
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("wrap_zero", bus.imem_addr, 64'h0);
      chk("wrap_ifid_pc", bus.if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);

      for (int i = 0; i < 3000; i++) begin
         mem_k = $urandom_range(1, 4);
         if ($urandom_range(0, 3) == 0)
            rd = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4);
         else
            rd = {$urandom, $urandom} & ~64'h3;
         step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) == 0), rd);
      end

      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("final_rst_valid", {63'd0, bus.if_id_valid}, 64'd0);
      chk("final_rst_addr", bus.imem_addr, 64'h100);
`ifdef FETCH_PERF_EN
      chk("final_perf_f", {32'd0, perf_fetched}, 64'd0);
      chk("final_perf_d", {32'd0, perf_dropped}, 64'd0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
